muldiv_sched: RTL and testbench
===============================

# muldiv_sched

Two-requester scheduler for the shared iterative multiply/divide unit in the core execute stage. It arbitrates round-robin between two M-extension requesters (e.g. the main pipeline and the coprocessor port). It latches the granted operands and sequences the unit's req/ready handshake. It returns each result to its owner as a one-cycle response pulse. Only one operation is in flight at a time.

## Interface
- XLEN, 32, operand and result width
- clk_in  input  1  clock; all state changes on rising edge
- reset_in  input  1  asynchronous, active-high reset
- req0_valid_in  input  1  requester 0 has an operation
- req0_op_in  input  3  funct3 of the M operation (MUL..REMU encoding)
- req0_a_in, req0_b_in  input  XLEN  operands rs1, rs2
- req0_ready_out  output  1  request accepted this cycle
- resp0_valid_out  output  1  one-cycle pulse, result for requester 0
- resp0_data_out  output  XLEN  result; holds last value between pulses
- req1_* / resp1_*  same as requester 0
- unit_req_out  output  1  request to the mul/div unit; held until unit_ready_in
- unit_op_out  output  3  latched funct3
- unit_a_out, unit_b_out  output  XLEN  latched operands
- unit_ready_in  input  1  unit done; unit_result_in valid this cycle
- unit_result_in  input  XLEN  final, already sign-corrected result

## Operation
- States: IDLE, BUSY.
- IDLE:
  - Grant one valid requester.
  - On a tie, grant the requester not granted last. The last-grant register resets to 1, so requester 0 wins the first tie.
  - reqN_ready_out = IDLE & grantN, combinational. Accept = valid & ready.
- On accept:
  - Latch op, a, b and the owner ID.
  - Update last-grant.
  - Go to BUSY.
- Operands are captured at accept. The requester may change or drop its inputs on the next cycle.
- BUSY:
  - unit_req_out = 1 and unit_op/a/b_out = latched values.
  - Both reqN_ready_out are 0.
- Completion: when BUSY and unit_ready_in = 1:
  - Register unit_result_in into respN_data_out of the owner.
  - Pulse respN_valid_out on the next cycle.
  - Go to IDLE.
- unit_req_out is low for at least one cycle between operations.
- unit_ready_in outside BUSY is ignored.
- A requester's valid dropped before accept is legal; no request is recorded.

## Timing
- Reset values:
  - State IDLE, last-grant = 1.
  - All ready/valid/req outputs 0.
  - unit_op/a/b_out 0 and resp*_data_out 0.
  - Reuse tag invalid.
- Reset mid-BUSY clears state immediately. unit_req_out falls asynchronously and no response is issued. The unit shares reset_in.
- Latency from accept (cycle T) with unit_ready_in at cycle T+k (k ≥ 1):
  - unit_req_out is high T+1..T+k.
  - respN_valid_out is high at T+k+1.
  - The next accept is possible at T+k+1.
- Response pulse and a new accept can coincide in the same cycle.
- Back-to-back: a requester holding valid continuously is served every other operation while the other requester is also valid.

## Configuration
- MUL_DIV_REUSE_EN: result-reuse register {valid, op, a, b, result}.
  - The register is loaded on every unit completion.
  - In IDLE, a granted request whose op, a and b match a valid tag is accepted. It completes without the unit: respN_valid_out at T+1 with the tagged result, state stays IDLE, and unit_req_out stays 0.
  - Arbitration and last-grant update are unchanged.
- Undefined: no tag logic; every request goes through the unit.

## Test plan
- Reset held 3 cycles, released → all outputs 0; req0_ready_out = 1 once req0_valid_in rises.
- req0 MUL a=6 b=7, unit stub ready 3 cycles after unit_req rises, accept at T:
  - unit_req_out high T+1..T+3.
  - resp0_valid_out pulses at T+4 with data 42; resp1 is silent.
- Both requesters valid immediately after reset:
  - req0 (DIVU 100/7) accepted first, req1 (REMU 100/7) accepted at the response cycle.
  - Responses: resp0 = 14, then resp1 = 2.
- Both held valid for 4 operations → grants alternate 0, 1, 0, 1; no requester is served twice consecutively.
- reset_in asserted at the second BUSY cycle → unit_req_out 0 in the same cycle; no resp pulse after release; next accept works normally.
- With MUL_DIV_REUSE_EN, req1 DIV a=-100 b=7, unit returns 0xFFFFFFF2, then the identical request is repeated:
  - The repeat's resp1 = 0xFFFFFFF2 at T+1 and unit_req_out stays 0.
  - Without the macro, the repeat uses the unit with full latency.

Source files
------------

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - round-robin two-requester scheduler for the shared iterative mul/div unit
// Optional result-reuse register: define MUL_DIV_REUSE_EN.
module muldiv_sched #(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            req0_valid_in,
  input  logic [2:0]      req0_op_in,
  input  logic [XLEN-1:0] req0_a_in,
  input  logic [XLEN-1:0] req0_b_in,
  output logic            req0_ready_out,
  output logic            resp0_valid_out,
  output logic [XLEN-1:0] resp0_data_out,
  input  logic            req1_valid_in,
  input  logic [2:0]      req1_op_in,
  input  logic [XLEN-1:0] req1_a_in,
  input  logic [XLEN-1:0] req1_b_in,
  output logic            req1_ready_out,
  output logic            resp1_valid_out,
  output logic [XLEN-1:0] resp1_data_out,
  output logic            unit_req_out,
  output logic [2:0]      unit_op_out,
  output logic [XLEN-1:0] unit_a_out,
  output logic [XLEN-1:0] unit_b_out,
  input  logic            unit_ready_in,
  input  logic [XLEN-1:0] unit_result_in
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic            owner_q, owner_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic            resp0_valid_q, resp0_valid_d, resp1_valid_q, resp1_valid_d;
  logic [XLEN-1:0] resp0_data_q, resp0_data_d, resp1_data_q, resp1_data_d;

  logic            grant0, grant1, accept, hit;
  logic [2:0]      sel_op;
  logic [XLEN-1:0] sel_a, sel_b, reuse_result;

  // last_q names the requester granted most recently; the other one wins a tie
  assign grant0 = req0_valid_in & (~req1_valid_in | last_q);
  assign grant1 = req1_valid_in & (~req0_valid_in | ~last_q);
  assign accept = (state_q == IDLE) & (grant0 | grant1);
  assign sel_op = grant1 ? req1_op_in : req0_op_in;
  assign sel_a  = grant1 ? req1_a_in  : req0_a_in;
  assign sel_b  = grant1 ? req1_b_in  : req0_b_in;

`ifdef MUL_DIV_REUSE_EN
  logic            tag_valid_q;
  logic [2:0]      tag_op_q;
  logic [XLEN-1:0] tag_a_q, tag_b_q, tag_result_q;

  assign hit = tag_valid_q & (tag_op_q == sel_op) & (tag_a_q == sel_a) & (tag_b_q == sel_b);
  assign reuse_result = tag_result_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      tag_valid_q  <= 1'b0;
      tag_op_q     <= '0;
      tag_a_q      <= '0;
      tag_b_q      <= '0;
      tag_result_q <= '0;
    end else if (state_q == BUSY && unit_ready_in) begin
      tag_valid_q  <= 1'b1;
      tag_op_q     <= op_q;
      tag_a_q      <= a_q;
      tag_b_q      <= b_q;
      tag_result_q <= unit_result_in;
    end
  end
`else
  assign hit = 1'b0;
  assign reuse_result = '0;
`endif

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    owner_d        = owner_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    resp0_valid_d  = 1'b0;
    resp1_valid_d  = 1'b0;
    resp0_data_d   = resp0_data_q;
    resp1_data_d   = resp1_data_q;
    req0_ready_out = 1'b0;
    req1_ready_out = 1'b0;
    if (state_q == IDLE) begin
      req0_ready_out = grant0;
      req1_ready_out = grant1;
      if (accept) begin
        last_d = grant1;
        if (hit) begin
          if (grant1) begin
            resp1_valid_d = 1'b1;
            resp1_data_d  = reuse_result;
          end else begin
            resp0_valid_d = 1'b1;
            resp0_data_d  = reuse_result;
          end
        end else begin
          owner_d = grant1;
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = BUSY;
        end
      end
    end else if (unit_ready_in) begin
      state_d = IDLE;
      if (owner_q) begin
        resp1_valid_d = 1'b1;
        resp1_data_d  = unit_result_in;
      end else begin
        resp0_valid_d = 1'b1;
        resp0_data_d  = unit_result_in;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      owner_q       <= 1'b0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_data_q  <= resp0_data_d;
      resp1_data_q  <= resp1_data_d;
    end
  end

  // Decoded straight from state so an asynchronous reset drops the request at once
  assign unit_req_out    = (state_q == BUSY);
  assign unit_op_out     = op_q;
  assign unit_a_out      = a_q;
  assign unit_b_out      = b_q;
  assign resp0_valid_out = resp0_valid_q;
  assign resp1_valid_out = resp1_valid_q;
  assign resp0_data_out  = resp0_data_q;
  assign resp1_data_out  = resp1_data_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - directed self-checking bench for muldiv_sched with a latency-programmable unit stub
module tb_muldiv_sched;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        req0_valid_in = 1'b0, req1_valid_in = 1'b0;
  logic [2:0]  req0_op_in = '0, req1_op_in = '0;
  logic [31:0] req0_a_in = '0, req0_b_in = '0, req1_a_in = '0, req1_b_in = '0;
  logic        req0_ready_out, req1_ready_out;
  logic        resp0_valid_out, resp1_valid_out;
  logic [31:0] resp0_data_out, resp1_data_out;
  logic        unit_req_out;
  logic [2:0]  unit_op_out;
  logic [31:0] unit_a_out, unit_b_out;
  logic        unit_ready_in = 1'b0;
  logic [31:0] unit_result_in = '0;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cnt = 0;
  logic spurious = 1'b0;

  muldiv_sched #(.XLEN(32)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .req0_valid_in(req0_valid_in), .req0_op_in(req0_op_in), .req0_a_in(req0_a_in), .req0_b_in(req0_b_in),
    .req0_ready_out(req0_ready_out), .resp0_valid_out(resp0_valid_out), .resp0_data_out(resp0_data_out),
    .req1_valid_in(req1_valid_in), .req1_op_in(req1_op_in), .req1_a_in(req1_a_in), .req1_b_in(req1_b_in),
    .req1_ready_out(req1_ready_out), .resp1_valid_out(resp1_valid_out), .resp1_data_out(resp1_data_out),
    .unit_req_out(unit_req_out), .unit_op_out(unit_op_out), .unit_a_out(unit_a_out), .unit_b_out(unit_b_out),
    .unit_ready_in(unit_ready_in), .unit_result_in(unit_result_in)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb, sq;
    p  = {32'd0, a} * {32'd0, b};
    sa = a;
    sb = b;
    sq = sa / sb;
    case (op)
      3'd0:    return p[31:0];
      3'd3:    return p[63:32];
      3'd4:    return sq;
      3'd5:    return a / b;
      3'd7:    return a % b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Unit stub: raises ready on the lat-th cycle of unit_req_out
  always @(posedge clk_in) begin
    #1;
    if (reset_in || !unit_req_out) begin
      cnt = 0;
      unit_ready_in = spurious;
      unit_result_in = 32'h5A5A_5A5A;
    end else begin
      cnt = cnt + 1;
      unit_ready_in = (cnt == lat);
      unit_result_in = (cnt == lat) ? model(unit_op_out, unit_a_out, unit_b_out) : 32'hBAD0_BAD0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #2;
  endtask

  task automatic drive(input int rq, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (rq == 0) begin
      req0_valid_in = v; req0_op_in = op; req0_a_in = a; req0_b_in = b;
    end else begin
      req1_valid_in = v; req1_op_in = op; req1_a_in = a; req1_b_in = b;
    end
  endtask

  task automatic run_op(input int rq, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int l, input logic [31:0] exp);
    lat = l;
    drive(rq, 1'b1, op, a, b);
    #1;
    check("op_ready", rq == 1 ? req1_ready_out : req0_ready_out, 1);
    next_cycle();
    drive(rq, 1'b0, ~op, ~a, ~b);
    #1;
    check("op_unit_op", unit_op_out, op);
    check("op_unit_a", unit_a_out, a);
    check("op_unit_b", unit_b_out, b);
    for (int k = 1; k <= l; k++) begin
      if (k > 1) begin
        next_cycle();
        #1;
      end
      check("op_unit_req_busy", unit_req_out, 1);
      check("op_resp_early", rq == 1 ? resp1_valid_out : resp0_valid_out, 0);
    end
    next_cycle();
    #1;
    check("op_resp_valid", rq == 1 ? resp1_valid_out : resp0_valid_out, 1);
    check("op_resp_data", rq == 1 ? resp1_data_out : resp0_data_out, exp);
    check("op_other_silent", rq == 1 ? resp0_valid_out : resp1_valid_out, 0);
    check("op_unit_req_low", unit_req_out, 0);
    next_cycle();
    #1;
    check("op_resp_pulse_end", rq == 1 ? resp1_valid_out : resp0_valid_out, 0);
    check("op_resp_data_hold", rq == 1 ? resp1_data_out : resp0_data_out, exp);
  endtask

  typedef struct {
    int          rq;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          l;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int owner;
    int waited;
    logic any_resp;

    vecs[0] = '{0, 3'd0, 32'd6,          32'd7,          3, 32'd42};
    vecs[1] = '{1, 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1, 32'hFFFF_FFFE};
    vecs[2] = '{0, 3'd7, 32'd1000,       32'd33,         2, 32'd10};
    vecs[3] = '{1, 3'd5, 32'hFFFF_FFFF,  32'd16,         4, 32'h0FFF_FFFF};
    vecs[4] = '{0, 3'd4, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1, 32'd14};
    vecs[5] = '{1, 3'd0, 32'h0001_0000,  32'h0001_0000,  2, 32'd0};

    // Reset held for three cycles
    reset_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #2;
    reset_in = 1'b0;
    #1;
    check("rst_ready0", req0_ready_out, 0);
    check("rst_ready1", req1_ready_out, 0);
    check("rst_resp_valid", {resp0_valid_out, resp1_valid_out}, 0);
    check("rst_unit_req", unit_req_out, 0);
    check("rst_unit_op_a_b", {29'd0, unit_op_out} | unit_a_out | unit_b_out, 0);
    check("rst_resp_data", resp0_data_out | resp1_data_out, 0);

    // First tie after reset goes to requester 0; requester 1 is accepted on the response cycle
    lat = 2;
    drive(0, 1'b1, 3'd5, 32'd100, 32'd7);
    drive(1, 1'b1, 3'd7, 32'd100, 32'd7);
    #1;
    check("tie_ready0", req0_ready_out, 1);
    check("tie_ready1", req1_ready_out, 0);
    next_cycle();
    req0_valid_in = 1'b0;
    #1;
    check("tie_busy_ready1", req1_ready_out, 0);
    check("tie_busy_unit_req", unit_req_out, 1);
    next_cycle();
    #1;
    check("tie_busy2_unit_req", unit_req_out, 1);
    next_cycle();
    #1;
    check("tie_resp0_valid", resp0_valid_out, 1);
    check("tie_resp0_data", resp0_data_out, 14);
    check("tie_ready1_at_resp", req1_ready_out, 1);
    next_cycle();
    req1_valid_in = 1'b0;
    #1;
    check("tie_resp0_pulse_end", resp0_valid_out, 0);
    check("tie_unit_op1", unit_op_out, 7);
    next_cycle();
    next_cycle();
    #1;
    check("tie_resp1_valid", resp1_valid_out, 1);
    check("tie_resp1_data", resp1_data_out, 2);

    // Both held valid: grants alternate starting with requester 0
    lat = 1;
    drive(0, 1'b1, 3'd0, 32'd3, 32'd5);
    drive(1, 1'b1, 3'd0, 32'd4, 32'd5);
    owner = 0;
    for (int n = 0; n < 4; n++) begin
      waited = 0;
      any_resp = 1'b0;
      while (!any_resp && waited < 10) begin
        next_cycle();
        #1;
        waited++;
        any_resp = resp0_valid_out | resp1_valid_out;
      end
      check("alt_resp_seen", any_resp, 1);
      check("alt_resp0_owner", resp0_valid_out, owner == 0);
      check("alt_resp1_owner", resp1_valid_out, owner == 1);
      check("alt_data", owner == 1 ? resp1_data_out : resp0_data_out, owner == 1 ? 32'd20 : 32'd15);
      owner ^= 1;
    end
    req0_valid_in = 1'b0;
    req1_valid_in = 1'b0;
    repeat (3) next_cycle();
    #1;
    check("alt_drained", unit_req_out, 0);
    next_cycle();

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].rq, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].l, vecs[i].exp);

    // unit_ready_in while idle must not produce a response
    spurious = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    check("spurious_no_resp", {resp0_valid_out, resp1_valid_out}, 0);
    check("spurious_no_req", unit_req_out, 0);
    spurious = 1'b0;
    next_cycle();
    next_cycle();

    // Reset during the second BUSY cycle
    lat = 5;
    drive(0, 1'b1, 3'd0, 32'd2, 32'd3);
    next_cycle();
    req0_valid_in = 1'b0;
    next_cycle();
    #1;
    check("mid_busy_req_high", unit_req_out, 1);
    reset_in = 1'b1;
    #1;
    check("mid_reset_req_drop", unit_req_out, 0);
    next_cycle();
    reset_in = 1'b0;
    any_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      #1;
      any_resp = any_resp | resp0_valid_out | resp1_valid_out | unit_req_out;
    end
    check("mid_reset_silent", any_resp, 0);
    check("mid_reset_unit_a", unit_a_out, 0);
    next_cycle();
    run_op(0, 3'd0, 32'd9, 32'd9, 2, 32'd81);

    // Identical DIV repeated on requester 1
    run_op(1, 3'd4, 32'hFFFF_FF9C, 32'd7, 2, 32'hFFFF_FFF2);
`ifdef MUL_DIV_REUSE_EN
    drive(1, 1'b1, 3'd4, 32'hFFFF_FF9C, 32'd7);
    #1;
    check("reuse_ready1", req1_ready_out, 1);
    next_cycle();
    req1_valid_in = 1'b0;
    #1;
    check("reuse_resp1_valid", resp1_valid_out, 1);
    check("reuse_resp1_data", resp1_data_out, 32'hFFFF_FFF2);
    check("reuse_unit_req", unit_req_out, 0);
    next_cycle();
    #1;
    check("reuse_resp1_end", resp1_valid_out, 0);
    check("reuse_unit_req2", unit_req_out, 0);
`else
    run_op(1, 3'd4, 32'hFFFF_FF9C, 32'd7, 2, 32'hFFFF_FFF2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
